// File: rtl/countdown_timer.sv
// Two-stage down-counting timer: prescaler underflow ticks decrement a loaded count; done at zero.
// Latency: k-th tick and final done are registered, visible k*(PRESCALE+1) edges after load accept.
// Backpressure: load_ready is high only in IDLE; loads offered while running are dropped, not queued.
module countdown_timer #(
  parameter int PRE_WIDTH   = 4,
  parameter int CNT_WIDTH   = 3,
  parameter int PRESCALE    = 15,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 abort,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 tick,
  output logic                 done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PRE_WIDTH-1:0] PRE_RELOAD = PRE_WIDTH'(PRESCALE);
  localparam logic [PRE_WIDTH-1:0] PRE_ONE    = PRE_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;

  state_t               state, state_nxt;
  logic [PRE_WIDTH-1:0] pre, pre_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic [CNT_WIDTH-1:0] reload_reg, reload_nxt;
  logic                 tick_nxt, done_nxt;

  // Handshake and status flags are pure decodes of the state register.
  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);

  // Register all timer state; reset returns to an idle timer with a full prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre        <= PRE_RELOAD;
      count      <= CNT_ZERO;
      reload_reg <= CNT_ZERO;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      tick       <= tick_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state logic: load in IDLE, prescale/decrement in RUN; abort beats a same-cycle underflow.
  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre;
    count_nxt  = count;
    reload_nxt = reload_reg;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (load_valid) begin
          if (load_value == CNT_ZERO) begin
            // A zero delay completes immediately without entering RUN.
            done_nxt = 1'b1;
          end else begin
            count_nxt  = load_value;
            reload_nxt = load_value;
            pre_nxt    = PRE_RELOAD;
            state_nxt  = RUN;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = CNT_ZERO;
          pre_nxt   = PRE_RELOAD;
        end else if (pre != '0) begin
          pre_nxt = pre - PRE_ONE;
        end else begin
          pre_nxt  = PRE_RELOAD;
          tick_nxt = 1'b1;
          if (count > CNT_ONE) begin
            count_nxt = count - CNT_ONE;
          end else begin
            // Terminal count (count==0 is unreachable in RUN and is treated the same way).
            done_nxt = 1'b1;
            if (AUTO_RELOAD != 0) begin
              count_nxt = reload_reg;
            end else begin
              count_nxt = CNT_ZERO;
              state_nxt = IDLE;
            end
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: default instance checked against an event scoreboard, auto-reload instance by hand.
// Latency: expected tick/done events are queued at load time and matched against the edge they appear on.
// Backpressure: exercises ignored loads while running, abort, and a load in the done cycle.
module tb_countdown_timer;

  localparam int PERIOD = 16;  // PRESCALE+1 for the default instance

  typedef struct {
    int         at_edge;
    logic [2:0] cnt;
    logic       tk;
    logic       dn;
  } ev_t;

  typedef struct {
    logic [2:0] lv;
    logic       exp_busy;
    logic [2:0] exp_count;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid, abort;
  logic [2:0] load_value;
  logic       load_ready, busy, tick, done;
  logic [2:0] count;

  logic       ar_load_valid, ar_abort;
  logic [2:0] ar_load_value;
  logic       ar_load_ready, ar_busy, ar_tick, ar_done;
  logic [2:0] ar_count;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  ev_t q[$];
  ev_t mon_e;

  countdown_timer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .abort(abort), .busy(busy), .count(count),
    .tick(tick), .done(done)
  );

  countdown_timer #(.PRESCALE(0), .AUTO_RELOAD(1)) dut_ar (
    .clk(clk), .rst_n(rst_n), .load_valid(ar_load_valid), .load_ready(ar_load_ready),
    .load_value(ar_load_value), .abort(ar_abort), .busy(ar_busy), .count(ar_count),
    .tick(ar_tick), .done(ar_done)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every tick/done of the default instance must match the queue head.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at_edge < cyc) begin
      mon_e = q.pop_front();
      chk("missed_event", cyc, mon_e.at_edge);
    end
    if (tick || done) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, tick, done}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("event_edge", cyc, mon_e.at_edge);
        chk("event_count", count, mon_e.cnt);
        chk("event_tick", tick, mon_e.tk);
        chk("event_done", done, mon_e.dn);
      end
    end
  end

  task automatic push_events(input logic [2:0] v, input int acc);
    ev_t e;
    if (v == 3'd0) begin
      e.at_edge = acc; e.cnt = 3'd0; e.tk = 1'b0; e.dn = 1'b1;
      q.push_back(e);
    end else begin
      for (int k = 1; k <= int'(v); k++) begin
        e.at_edge = acc + k * PERIOD;
        e.cnt     = v - 3'(k);
        e.tk      = 1'b1;
        e.dn      = (k == int'(v));
        q.push_back(e);
      end
    end
  endtask

  // Call at a negedge; returns at the negedge just after the accepting edge.
  task automatic do_load(input logic [2:0] v, output int acc);
    acc = cyc + 1;
    push_events(v, acc);
    load_valid = 1'b1;
    load_value = v;
    @(negedge clk);
    load_valid = 1'b0;
    load_value = 3'd0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, q.size(), 0);
    q.delete();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    vec_t tbl[5];
    int   acc, acc2;

    tbl[0] = '{lv: 3'd3, exp_busy: 1'b1, exp_count: 3'd3};
    tbl[1] = '{lv: 3'd0, exp_busy: 1'b0, exp_count: 3'd0};
    tbl[2] = '{lv: 3'd1, exp_busy: 1'b1, exp_count: 3'd1};
    tbl[3] = '{lv: 3'd7, exp_busy: 1'b1, exp_count: 3'd7};
    tbl[4] = '{lv: 3'd2, exp_busy: 1'b1, exp_count: 3'd2};

    load_valid = 0; load_value = 0; abort = 0;
    ar_load_valid = 0; ar_load_value = 0; ar_abort = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_ar_ready", ar_load_ready, 1);
    chk("rst_ar_busy", ar_busy, 0);
    chk("rst_ar_count", ar_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // Table: main loads of several sizes, including zero.
    for (int i = 0; i < 5; i++) begin
      do_load(tbl[i].lv, acc);
      chk("accept_busy", busy, tbl[i].exp_busy);
      chk("accept_ready", load_ready, !tbl[i].exp_busy);
      chk("accept_count", count, tbl[i].exp_count);
      wait_drain("drain_table", 8 * PERIOD + 20);
      chk_idle("table_end");
    end

    // Back-to-back: new load offered in the cycle done is high.
    do_load(3'd1, acc);
    while (cyc < acc + PERIOD) @(negedge clk);
    chk("b2b_done", done, 1);
    chk("b2b_ready", load_ready, 1);
    do_load(3'd2, acc2);
    chk("b2b_busy", busy, 1);
    chk("b2b_count", count, 2);
    wait_drain("drain_b2b", 3 * PERIOD + 20);
    chk_idle("b2b_end");

    // Abort in the very cycle the prescaler underflows: no tick, no done.
    acc = cyc + 1;
    begin
      ev_t e;
      e.at_edge = acc + PERIOD; e.cnt = 3'd4; e.tk = 1'b1; e.dn = 1'b0;
      q.push_back(e);
    end
    load_valid = 1'b1; load_value = 3'd5;
    @(negedge clk);
    load_valid = 1'b0;
    while (cyc < acc + 2 * PERIOD - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_tick", tick, 0);
    chk("abort_done", done, 0);
    chk_idle("abort");
    repeat (40) @(negedge clk);
    chk("abort_queue", q.size(), 0);
    q.delete();

    // Load offered while running is dropped.
    do_load(3'd4, acc);
    while (cyc < acc + 5) @(negedge clk);
    load_valid = 1'b1; load_value = 3'd7;
    @(negedge clk);
    load_valid = 1'b0; load_value = 3'd0;
    chk("ignored_load_count", count, 4);
    chk("ignored_load_busy", busy, 1);
    wait_drain("drain_ignored", 5 * PERIOD + 20);
    chk_idle("ignored_end");

    // Asynchronous reset between edges mid-run.
    do_load(3'd3, acc);
    while (cyc < acc + 20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_ready", load_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_done", done, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load(3'd3, acc);
    chk("post_midrst_busy", busy, 1);
    wait_drain("drain_post_midrst", 4 * PERIOD + 20);
    chk_idle("post_midrst_end");

    // Auto-reload instance with PRESCALE=0: tick every cycle, count 1,2,1,2..., done on each reload.
    ar_load_valid = 1'b1; ar_load_value = 3'd2;
    @(negedge clk);
    ar_load_valid = 1'b0; ar_load_value = 3'd0;
    chk("ar_load_count", ar_count, 2);
    chk("ar_load_busy", ar_busy, 1);
    chk("ar_load_tick", ar_tick, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("ar_tick", ar_tick, 1);
      chk("ar_count", ar_count, (k % 2 == 1) ? 1 : 2);
      chk("ar_done", ar_done, (k % 2 == 0) ? 1 : 0);
      chk("ar_busy", ar_busy, 1);
    end
    ar_abort = 1'b1;
    @(negedge clk);
    ar_abort = 1'b0;
    chk("ar_abort_busy", ar_busy, 0);
    chk("ar_abort_count", ar_count, 0);
    chk("ar_abort_ready", ar_load_ready, 1);
    chk("ar_abort_tick", ar_tick, 0);
    chk("ar_abort_done", ar_done, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
